// File: rtl/spi_txn_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : spi_txn_fsm
//  Description : SPI memory-slave transaction controller. Tracks one
//                address/R-W byte followed by one data byte per chip-select
//                frame and sequences the address latch, shift-register load,
//                data-memory write and MISO output enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_txn_fsm #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             cs_n,
    input  logic             sclk_pos,
    input  logic             sclk_neg,
    input  logic             rw_bit,
    output logic             addr_we,
    output logic             sr_we,
    output logic             dm_we,
    output logic             miso_en,
    output logic             busy,
    output logic [CNT_W-1:0] bit_count
);

    localparam logic [2:0] c_IDLE         = 3'd0;
    localparam logic [2:0] c_GET_ADDR     = 3'd1;
    localparam logic [2:0] c_GOT_ADDR     = 3'd2;
    localparam logic [2:0] c_READ_LOAD    = 3'd3;
    localparam logic [2:0] c_READ_SHIFT   = 3'd4;
    localparam logic [2:0] c_WRITE_SHIFT  = 3'd5;
    localparam logic [2:0] c_WRITE_COMMIT = 3'd6;
    localparam logic [2:0] c_DONE         = 3'd7;

    // Address phase carries the R/W flag as one extra bit.
    localparam logic [CNT_W-1:0] c_ADDR_LAST = CNT_W'(ADDR_BITS + 1);
    localparam logic [CNT_W-1:0] c_DATA_LAST = CNT_W'(DATA_BITS);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_inc;

    assign count_inc = count_q + CNT_W'(1);

    // Next-state and bit-counter logic; a raised chip select overrides any edge.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if ((state_q != c_IDLE) && cs_n) begin
            state_d = c_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                c_IDLE: begin
                    count_d = '0;
                    if (!cs_n) begin
                        state_d = c_GET_ADDR;
                    end
                end
                c_GET_ADDR: begin
                    if (sclk_pos) begin
                        count_d = count_inc;
                        if (count_inc == c_ADDR_LAST) begin
                            state_d = c_GOT_ADDR;
                        end
                    end
                end
                c_GOT_ADDR: begin
                    count_d = '0;
                    state_d = rw_bit ? c_READ_LOAD : c_WRITE_SHIFT;
                end
                c_READ_LOAD: begin
                    state_d = c_READ_SHIFT;
                end
                c_READ_SHIFT: begin
                    // Read data leaves on falling edges so the master samples on rising.
                    if (sclk_neg) begin
                        count_d = count_inc;
                        if (count_inc == c_DATA_LAST) begin
                            state_d = c_DONE;
                        end
                    end
                end
                c_WRITE_SHIFT: begin
                    if (sclk_pos) begin
                        count_d = count_inc;
                        if (count_inc == c_DATA_LAST) begin
                            state_d = c_WRITE_COMMIT;
                        end
                    end
                end
                c_WRITE_COMMIT: begin
                    state_d = c_DONE;
                end
                c_DONE: begin
                    state_d = c_DONE;
                end
                default: begin
                    state_d = c_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= c_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Moore output decode from the state register only.
    always_comb begin
        addr_we   = (state_q == c_GOT_ADDR);
        sr_we     = (state_q == c_READ_LOAD);
        dm_we     = (state_q == c_WRITE_COMMIT);
        miso_en   = (state_q == c_READ_SHIFT);
        busy      = (state_q != c_IDLE);
        bit_count = count_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_txn_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_txn_fsm
//  Description : Directed self-checking bench for spi_txn_fsm with an
//                expected-output queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_txn_fsm;

    localparam int ADDR_BITS = 7;
    localparam int DATA_BITS = 8;
    localparam int CNT_W     = 4;
    localparam int VW        = CNT_W + 5;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             cs_n;
    logic             sclk_pos;
    logic             sclk_neg;
    logic             rw_bit;
    logic             addr_we;
    logic             sr_we;
    logic             dm_we;
    logic             miso_en;
    logic             busy;
    logic [CNT_W-1:0] bit_count;

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] exp_q[$];
    string         tag_q[$];

    spi_txn_fsm #(
        .ADDR_BITS(ADDR_BITS),
        .DATA_BITS(DATA_BITS),
        .CNT_W    (CNT_W)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .cs_n     (cs_n),
        .sclk_pos (sclk_pos),
        .sclk_neg (sclk_neg),
        .rw_bit   (rw_bit),
        .addr_we  (addr_we),
        .sr_we    (sr_we),
        .dm_we    (dm_we),
        .miso_en  (miso_en),
        .busy     (busy),
        .bit_count(bit_count)
    );

    always #5 Clk = ~Clk;

    // Expected vector: {addr_we, sr_we, dm_we, miso_en, busy, bit_count}
    function automatic logic [VW-1:0] ev(input logic a, input logic s, input logic d,
                                         input logic m, input logic b, input int c);
        return {a, s, d, m, b, CNT_W'(c)};
    endfunction

    task automatic compare();
        logic [VW-1:0] exp_v;
        logic [VW-1:0] obs_v;
        string         tag;
        exp_v = exp_q.pop_front();
        tag   = tag_q.pop_front();
        obs_v = {addr_we, sr_we, dm_we, miso_en, busy, bit_count};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs_v, exp_v);
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the edge.
    task automatic cyc(input string tag, input logic cs, input logic sp, input logic sn,
                       input logic rw, input logic [VW-1:0] e);
        cs_n     = cs;
        sclk_pos = sp;
        sclk_neg = sn;
        rw_bit   = rw;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge Clk);
        #1;
        compare();
    endtask

    // From IDLE: open frame, shift 8 address/RW bits, leave GOT_ADDR.
    task automatic addr_phase(input logic rw);
        cyc("start", 1'b0, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 0, 1, 0));
        for (int k = 1; k <= ADDR_BITS + 1; k++) begin
            if (k < ADDR_BITS + 1)
                cyc("addr_shift", 1'b0, 1'b1, 1'b0, ~rw, ev(0, 0, 0, 0, 1, k));
            else
                cyc("addr_we", 1'b0, 1'b1, 1'b0, rw, ev(1, 0, 0, 0, 1, k));
        end
        if (rw) begin
            cyc("sr_we", 1'b0, 1'b0, 1'b0, rw, ev(0, 1, 0, 0, 1, 0));
            cyc("miso_start", 1'b0, 1'b0, 1'b0, rw, ev(0, 0, 0, 1, 1, 0));
        end else begin
            cyc("wshift_start", 1'b0, 1'b0, 1'b0, rw, ev(0, 0, 0, 0, 1, 0));
        end
    endtask

    task automatic write_data_full();
        for (int k = 1; k <= DATA_BITS; k++) begin
            if (k < DATA_BITS)
                cyc("wdata", 1'b0, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 0, 1, k));
            else
                cyc("dm_we", 1'b0, 1'b1, 1'b0, 1'b0, ev(0, 0, 1, 0, 1, k));
        end
        cyc("done_w", 1'b0, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 0, 1, DATA_BITS));
    endtask

    task automatic end_frame();
        cyc("cs_release", 1'b1, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        Reset    = 1'b1;
        cs_n     = 1'b1;
        sclk_pos = 1'b0;
        sclk_neg = 1'b0;
        rw_bit   = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        exp_q.push_back(ev(0, 0, 0, 0, 0, 0));
        tag_q.push_back("in_reset");
        compare();
        Reset = 1'b0;
        cyc("post_reset", 1'b1, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, 0));

        // Write frame to address 0x15 with ignored sclk_neg during address.
        cyc("start", 1'b0, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 0, 1, 0));
        cyc("addr1", 1'b0, 1'b1, 1'b0, 1'b1, ev(0, 0, 0, 0, 1, 1));
        cyc("addr_neg_ign", 1'b0, 1'b0, 1'b1, 1'b0, ev(0, 0, 0, 0, 1, 1));
        for (int k = 2; k <= 7; k++)
            cyc("addr", 1'b0, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 0, 1, k));
        cyc("addr_neg_ign2", 1'b0, 1'b0, 1'b1, 1'b0, ev(0, 0, 0, 0, 1, 7));
        cyc("addr_we", 1'b0, 1'b1, 1'b0, 1'b0, ev(1, 0, 0, 0, 1, 8));
        cyc("wshift_start", 1'b0, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 0, 1, 0));
        write_data_full();
        // Ignored edges in DONE.
        for (int k = 0; k < 3; k++)
            cyc("done_ignore", 1'b0, 1'b1, 1'b1, 1'b1, ev(0, 0, 0, 0, 1, DATA_BITS));
        end_frame();

        // Read frame; an sclk_pos during READ_SHIFT must be ignored.
        addr_phase(1'b1);
        for (int k = 1; k <= DATA_BITS; k++) begin
            if (k == 4)
                cyc("rd_pos_ign", 1'b0, 1'b1, 1'b0, 1'b1, ev(0, 0, 0, 1, 1, 3));
            if (k < DATA_BITS)
                cyc("rdata", 1'b0, 1'b0, 1'b1, 1'b1, ev(0, 0, 0, 1, 1, k));
            else
                cyc("rd_done", 1'b0, 1'b0, 1'b1, 1'b1, ev(0, 0, 0, 0, 1, k));
        end
        end_frame();

        // Abort write after 5th data bit, then a normal write frame.
        addr_phase(1'b0);
        for (int k = 1; k <= 5; k++)
            cyc("wdata_ab", 1'b0, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 0, 1, k));
        cyc("abort", 1'b1, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, 0));
        cyc("abort_idle", 1'b1, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, 0));
        addr_phase(1'b0);
        write_data_full();
        end_frame();

        // Collision: cs_n rises with the final data sclk_pos.
        addr_phase(1'b0);
        for (int k = 1; k <= 7; k++)
            cyc("wdata_col", 1'b0, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 0, 1, k));
        cyc("collision", 1'b1, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, 0));
        cyc("collision_idle", 1'b1, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, 0));

        // Reset mid GET_ADDR at count 5 with cs_n held low.
        cyc("start_r", 1'b0, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 0, 1, 0));
        for (int k = 1; k <= 5; k++)
            cyc("addr_r", 1'b0, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 0, 1, k));
        Reset    = 1'b1;
        sclk_pos = 1'b0;
        #1;
        exp_q.push_back(ev(0, 0, 0, 0, 0, 0));
        tag_q.push_back("async_reset");
        compare();
        cyc("reset_edge", 1'b0, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, 0));
        Reset = 1'b0;
        cyc("fresh_frame", 1'b0, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 0, 1, 0));
        cyc("fresh_addr1", 1'b0, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 0, 1, 1));
        end_frame();

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
